// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage and the hazard/forwarding controller.
// master: pipeline side (drives ID fields, consumes controls).
// slave : pipe_hazard_ctrl (consumes ID fields, drives controls).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [4:0]       id_wn;
    logic             stall;
    logic             bubble;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wn,
        input  stall, bubble, fwda, fwdb, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wn,
        output stall, bubble, fwda, fwdb, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a five-stage pipeline.
// Tracks the destinations of the instructions in EX, MEM and WB and compares
// them with the sources of the instruction in ID.
// Build option FORWARD_EN: when defined, full EX/MEM/WB forwarding with a
// single-cycle load-use stall; when undefined, no forwarding and the consumer
// stalls until its producer has left WB.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               clrn,
    pipe_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic [4:0] wn;
    } slot_t;

    slot_t            e_q;
    slot_t            m_q;
    slot_t            w_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stall;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;

    logic e_a, e_b, m_a, m_b, w_a, w_b;

    // A slot supplies source r only if it really writes r, r is not the
    // hard-wired zero register, and the ID instruction actually reads r.
    function automatic logic hit(input slot_t s, input logic [4:0] r, input logic use_r);
        return s.valid && s.wreg && (s.wn == r) && (r != 5'd0) && use_r;
    endfunction

    assign e_a = hit(e_q, bus.id_rs, bus.id_use_rs);
    assign e_b = hit(e_q, bus.id_rt, bus.id_use_rt);
    assign m_a = hit(m_q, bus.id_rs, bus.id_use_rs);
    assign m_b = hit(m_q, bus.id_rt, bus.id_use_rt);
    assign w_a = hit(w_q, bus.id_rs, bus.id_use_rs);
    assign w_b = hit(w_q, bus.id_rt, bus.id_use_rt);

`ifdef FORWARD_EN
    // Only EX needs to remember whether it is a load: a load in MEM is
    // forwarded (the MEM mux picks memOut itself), so it never stalls.
    logic e_m2reg_q;

    // Nearest producer wins: EX over MEM over WB.
    function automatic logic [1:0] fwd_sel(input logic he, input logic hm, input logic hw);
        if (he)      return 2'b01;
        else if (hm) return 2'b10;
        else if (hw) return 2'b11;
        else         return 2'b00;
    endfunction

    // Load-use stall detection and forward-select generation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        stall = 1'b0;
        fwda  = 2'b00;
        fwdb  = 2'b00;
        if ((e_a || e_b) && e_m2reg_q) begin
            stall = 1'b1;
        end else begin
            fwda = fwd_sel(e_a, m_a, w_a);
            fwdb = fwd_sel(e_b, m_b, w_b);
        end
    end

    // EX-slot load flag follows the EX slot; a bubble is never a load.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) e_m2reg_q <= 1'b0;
        else       e_m2reg_q <= stall ? 1'b0 : bus.id_m2reg;
    end
`else
    // Without forwarding any pending producer of a source blocks the consumer.
    always_comb begin
        stall = 1'b0;
        fwda  = 2'b00;
        fwdb  = 2'b00;
        if (e_a || e_b || m_a || m_b || w_a || w_b) stall = 1'b1;
    end
`endif

    // Tracker shift: slots always advance; a stall inserts an empty slot in EX.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // slot samples its neighbour's pre-edge value, giving a true shift.
            w_q <= m_q;
            m_q <= e_q;
            if (stall) e_q <= '0;
            else       e_q <= '{valid: 1'b1, wreg: bus.id_wreg, wn: bus.id_wn};
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                        cnt_q <= '0;
        else if (stall && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
    end

    assign bus.stall     = stall;
    assign bus.bubble    = stall;
    assign bus.fwda      = fwda;
    assign bus.fwdb      = fwdb;
    assign bus.stall_cnt = cnt_q;

endmodule
